// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage between execute and write-back. Accepts one load/store request
//   at a time, checks it for alignment/range/opcode faults, drives a single-cycle
//   strobe to a synchronous data memory and returns a response to write-back.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready             request handshake from execute
//   req_read, req_write             operation (load / store)
//   req_addr, req_wdata             byte address and store data
//   dm_mem_read, dm_mem_write       data-memory strobes (one cycle each)
//   dm_address, dm_write_data       data-memory address / store data
//   dm_read_data                    data-memory read data, one clock after strobe
//   rsp_valid/rsp_ready             response handshake to write-back
//   rsp_data, rsp_err               load data (0 for stores/errors), fault flag
//   stall                           busy indicator, inverse of req_ready
//   cnt_load, cnt_store, cnt_err    saturating 16-bit event counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request
// ISSUE_RD | read strobe to memory, address driven
// CAPTURE  | memory data valid, registered into rsp_data at end of cycle
// ISSUE_WR | write strobe to memory, address and data driven
// RESP     | response held until write-back accepts it

`ifndef WORD
`define WORD 64
`endif

module load_store_unit #(
  parameter int WORD  = `WORD,
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            dm_mem_read,
  output logic            dm_mem_write,
  output logic [WORD-1:0] dm_address,
  output logic [WORD-1:0] dm_write_data,
  input  logic [WORD-1:0] dm_read_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_data,
  output logic            rsp_err,
  output logic            stall,
  output logic [15:0]     cnt_load,
  output logic [15:0]     cnt_store,
  output logic [15:0]     cnt_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RD = 3'd1,
    CAPTURE  = 3'd2,
    ISSUE_WR = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] word_idx;
  logic            accept;
  logic            req_err;
  logic            rsp_done;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only IDLE drives req_ready, so acceptance and the response handshake can
  // never coincide.
  assign accept   = req_valid && (state == IDLE);
  assign rsp_done = (state == RESP) && rsp_ready;
  assign word_idx = req_addr >> 3;
  assign req_err  = (req_addr[2:0] != 3'b000) ||
                    (word_idx >= WORD'(DEPTH)) ||
                    (req_read && req_write);
  assign stall    = ~req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobes and the memory bus come from the state register only, so a reset
  // mid-access drops them immediately.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_address    = '0;
    dm_write_data = '0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err || !(req_read || req_write)) state_nxt = RESP;
          else if (req_read)                       state_nxt = ISSUE_RD;
          else                                     state_nxt = ISSUE_WR;
        end
      end
      ISSUE_RD: begin
        dm_mem_read   = 1'b1;
        dm_address    = addr_q;
        dm_write_data = wdata_q;
        state_nxt     = CAPTURE;
      end
      CAPTURE: begin
        dm_address    = addr_q;
        dm_write_data = wdata_q;
        state_nxt     = RESP;
      end
      ISSUE_WR: begin
        dm_mem_write  = 1'b1;
        dm_address    = addr_q;
        dm_write_data = wdata_q;
        state_nxt     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rsp_data <= '0;
        rsp_err  <= req_err;
        if (req_err) cnt_err <= sat_inc(cnt_err);
      end
      if (state == CAPTURE) begin
        rsp_data <= dm_read_data;
        cnt_load <= sat_inc(cnt_load);
      end
      if (state == ISSUE_WR) cnt_store <= sat_inc(cnt_store);
      // Clear after the handshake so a stale response never leaks into the
      // next one.
      if (rsp_done) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule
